// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl
//
// Bit-serial subtractor. It computes d = a - b - bin (mod 2^WIDTH) and the
// final borrow bout, LSB first, one bit per clock. A single full-subtractor
// cell and one borrow flop do the arithmetic.
//
// Ports
//   clk    in   single clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request a new subtraction (accepted when ready=1)
//   clr    in   synchronous abort, has priority over start
//   a, b   in   WIDTH-bit unsigned minuend / subtrahend
//   bin    in   borrow-in
//   ready  out  start will be accepted on the next edge
//   busy   out  bits are being processed
//   done   out  one-cycle pulse, d/bout just updated
//   d      out  registered difference
//   bout   out  registered final borrow
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | processing one operand bit per clock
// DONE  | result valid (done pulse); start here chains the next operation

module serial_subtract_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clr,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             bout_q, bout_d;
    logic             bw_q, bw_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             bit_diff;
    logic             bit_borrow;
    logic             last_bit;

    // Full-subtractor cell on the current operand LSBs.
    assign bit_diff   = a_q[0] ^ b_q[0] ^ bw_q;
    assign bit_borrow = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & bw_q);
    assign last_bit   = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        bw_d    = bw_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        bout_d  = bout_q;

        if (clr) begin
            state_d = IDLE;
            cnt_d   = '0;
            bw_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_d     = a;
                        b_d     = b;
                        bw_d    = bin;
                        cnt_d   = '0;
                        state_d = SHIFT;
                    end else begin
                        state_d = IDLE;
                    end
                end
                SHIFT: begin
                    r_d  = {bit_diff, r_q[WIDTH-1:1]};
                    a_d  = a_q >> 1;
                    b_d  = b_q >> 1;
                    bw_d = bit_borrow;
                    if (last_bit) begin
                        // Hold the counter at its last value rather than letting it wrap.
                        dout_d  = {bit_diff, r_q[WIDTH-1:1]};
                        bout_d  = bit_borrow;
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
            bw_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
            bw_q    <= bw_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy  = (state_q == SHIFT);
    assign ready = (state_q != SHIFT);
    assign done  = (state_q == DONE);
    assign d     = dout_q;
    assign bout  = bout_q;

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
module tb_serial_subtract_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         clr;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;

    serial_subtract_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .clr   (clr),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    typedef struct {
        logic [W:0] res;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         edge_n   = 0;
    logic [W:0] last_res = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every done must match the oldest outstanding
    // operation, both in value and in the edge it arrives on.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'({bout, d}), 32'(e.res));
                    chk("latency", edge_n, e.due);
                    last_res = e.res;
                end
            end else if (sb.size() > 0 && edge_n > sb[0].due) begin
                e = sb.pop_front();
                chk("done_timeout", 32'(done), 32'd1);
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic binv);
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 32'(ready), 32'd1);
        a     = av;
        b     = bv;
        bin   = binv;
        start = 1'b1;
        sb.push_back('{res: {1'b0, av} - {1'b0, bv} - (W+1)'(binv), due: edge_n + W + 1});
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        bin   = 1'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < W + 4) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 4 * W) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        start = 1'b0;
        clr   = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        #1;
        chk("rst_d", 32'(d), 32'd0);
        chk("rst_bout", 32'(bout), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic operation with busy/ready profile.
        issue(8'h5A, 8'h3C, 1'b0);
        chk("busy_e0", 32'(busy), 32'd1);
        for (int k = 1; k < W; k++) begin
            @(negedge clk);
            chk("busy_shift", 32'(busy), 32'd1);
            chk("ready_shift", 32'(ready), 32'd0);
        end
        @(negedge clk);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("ready_at_done", 32'(ready), 32'd1);
        chk("done_high", 32'(done), 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        wait_idle();

        // Underflow, then back-to-back start in the DONE cycle.
        issue(8'h00, 8'h01, 1'b0);
        wait_done();
        issue(8'h10, 8'h0F, 1'b1);
        wait_idle();

        // start during SHIFT is ignored.
        issue(8'h5A, 8'h3C, 1'b0);
        for (int k = 0; k < 3; k++) begin
            a     = 8'hFF;
            b     = 8'h00;
            start = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        // clr with start at edge 3: abort, hold outputs, no acceptance.
        issue(8'h33, 8'h11, 1'b0);
        @(negedge clk);
        @(negedge clk);
        clr   = 1'b1;
        start = 1'b1;
        a     = 8'hAA;
        e     = sb.pop_back();
        @(negedge clk);
        chk("clr_ready", 32'(ready), 32'd1);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_done", 32'(done), 32'd0);
        chk("clr_hold", 32'({bout, d}), 32'(last_res));
        clr   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("clr_no_accept", 32'(busy), 32'd0);
        repeat (W + 2) @(negedge clk);

        // Asynchronous reset mid-operation.
        issue(8'h5A, 8'h3C, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_d", 32'(d), 32'd0);
        chk("arst_bout", 32'(bout), 32'd0);
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        e        = sb.pop_back();
        last_res = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(8'h80, 8'h01, 1'b0);
        wait_idle();

        // Random operations, mixing back-to-back and gapped starts.
        for (int i = 0; i < 1000; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom));
            wait_done();
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_subtract_ctrl.md
SERIAL_SUBTRACT_CTRL -- requirements
Module: serial_subtract_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a new subtraction; sampled on clk rising edge.
REQ-005 SHALL have port clr  input  1  synchronous abort of any operation in progress.
REQ-006 SHALL have port a  input  WIDTH  minuend, unsigned, captured at start acceptance.
REQ-007 SHALL have port b  input  WIDTH  subtrahend, unsigned, captured at start acceptance.
REQ-008 SHALL have port bin  input  1  borrow-in, captured at start acceptance.
REQ-009 SHALL have port ready  output  1  high when start will be accepted.
REQ-010 SHALL have port busy  output  1  high while bits are being processed.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking a valid result.
REQ-012 SHALL have port d  output  WIDTH  registered difference a - b - bin, modulo 2^WIDTH.
REQ-013 SHALL have port bout  output  1  registered final borrow; 1 when a < b + bin.

Function
REQ-014 SHALL compute the result bit-serially, LSB first, one bit per clock, using a single 1-bit full-subtractor cell (diff = x^y^bw; borrow = (~x&y) | (~(x^y)&bw)) and one borrow flop.
REQ-015 SHALL implement states IDLE, SHIFT, DONE; SHIFT is the only state with busy=1.
REQ-016 ready SHALL equal 1 in IDLE and DONE, 0 in SHIFT.
REQ-017 IDLE: start=1 and clr=0 at an edge -> load a, b into shift registers, borrow flop <= bin, bit counter <= 0, go to SHIFT.
REQ-018 SHIFT: each edge processes the operand LSBs, shifts the difference bit into the MSB of the result shift register, shifts operands right, updates the borrow flop, increments the counter.
REQ-019 SHIFT: the edge processing bit WIDTH-1 SHALL copy the result shift register to d, the final borrow to bout, and go to DONE.
REQ-020 Latency: with the start-accepting edge as edge 0, d/bout SHALL update and done SHALL rise at edge WIDTH; done SHALL be high for exactly one cycle.
REQ-021 DONE: start=1 -> accept new operands exactly as in IDLE (back-to-back operation, no idle cycle); start=0 -> go to IDLE.
REQ-022 start SHALL be ignored in SHIFT; operand inputs SHALL be ignored outside the accepting edge.
REQ-023 d and bout SHALL hold their last value until the next completed operation; they SHALL NOT show partial results.
REQ-024 clr=1 at any edge SHALL force IDLE, clear the counter and borrow flop, leave d/bout unchanged, produce no done pulse; clr has priority over start.
REQ-025 Counter SHALL be ceil(log2(WIDTH)) bits minimum and SHALL NOT wrap inside an operation.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, ready=1, busy=0, done=0, d=0, bout=0, counter=0, borrow flop=0, independent of clk.
REQ-027 Reset asserted mid-operation SHALL discard the operation with no done pulse; the first start after rst_n deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 a=0x5A, b=0x3C, bin=0, start at edge 0 -> busy edges 1..7 high, done at edge 8, d=0x1E, bout=0.
REQ-029 a=0x00, b=0x01, bin=0 -> d=0xFF, bout=1; then a=0x10, b=0x0F, bin=1 started in the DONE cycle -> d=0x00, bout=0, done 8 edges later.
REQ-030 start pulsed with a=0xFF during SHIFT of 0x5A-0x3C -> ignored, result still 0x1E, single done pulse.
REQ-031 rst_n low at edge 4 of an operation -> all outputs 0 immediately, no done; next op 0x80-0x01 -> d=0x7F, bout=0.
REQ-032 clr at edge 3, with start also high -> IDLE, no done, d/bout hold previous values, start not accepted.
REQ-033 Exhaustive random: 1000 operations vs reference model {bout,d} = a - b - bin (9-bit); zero mismatches.
